// File: rtl/io_irq_mem_pkg.sv
// Shared constants for the IO memory / vectored interrupt controller:
// CSR word offsets, FSM state encodings and the spurious-vector id.
package io_irq_mem_pkg;

    localparam logic [1:0] CSR_MASK = 2'd0;
    localparam logic [1:0] CSR_PEND = 2'd1;
    localparam logic [1:0] CSR_VEC  = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // An ack with nothing pending reports the id one past the last channel.
    function automatic int spurious_id(input int n_ch);
        return n_ch;
    endfunction

endpackage

// File: rtl/io_irq_mem_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins; with no request
// the spurious id (N_CH) is reported.
module io_irq_mem_prio_enc
    import io_irq_mem_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]              req,
    output logic [$clog2(N_CH+1)-1:0]    id,
    output logic                         any
);

    localparam int IDW = $clog2(N_CH + 1);

    always_comb begin
        any = |req;
        id  = IDW'(spurious_id(N_CH));
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/io_irq_mem.sv
// Byte-addressed, word-wide IO memory on the shared tri-state CPU bus with an
// N_CH-channel vectored interrupt controller (edge capture, mask, priority, intr/inta).
module io_irq_mem
    import io_irq_mem_pkg::*;
#(
    parameter int                 ADDR_W   = 12,
    parameter int                 DATA_W   = 32,
    parameter int                 N_CH     = 4,
    parameter logic [ADDR_W-1:0]  CSR_BASE = 'hFF0,
    parameter logic [DATA_W-1:0]  VEC_RST  = 'h3C0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                rd,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   in,
    input  logic [N_CH-1:0]     irq_src,
    input  logic                inta,
    output logic                intr,
    output logic [DATA_W-1:0]   out
);

    localparam int IDW = $clog2(N_CH + 1);
    localparam int WAW = ADDR_W - 2;
    localparam logic [WAW-1:0] CSR_WORD = CSR_BASE[ADDR_W-1:2];

    logic [7:0]         mem [2**ADDR_W];
    logic [WAW-1:0]     waddr;
    logic [WAW-1:0]     csr_off;
    logic               csr_hit;
    logic [1:0]         csr_sel;
    logic               csr_wr;
    logic               mem_wr;
    logic [DATA_W-1:0]  mem_word;
    logic [DATA_W-1:0]  csr_word;
    logic [DATA_W-1:0]  vector;
    logic [DATA_W-1:0]  vec_base;
    logic [N_CH-1:0]    mask;
    logic [N_CH-1:0]    pend;
    logic [N_CH-1:0]    pend_m;
    logic [N_CH-1:0]    pend_n;
    logic [N_CH-1:0]    sync1;
    logic [N_CH-1:0]    sync2;
    logic [N_CH-1:0]    prev;
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    w1c_clr;
    logic [N_CH-1:0]    ack_clr;
    logic [IDW-1:0]     win_id;
    logic [IDW-1:0]     vec_id;
    logic               win_any;
    logic               ack_take;
    logic               ack_out;
    logic               drive;
    logic [0:0]         state;
    logic [0:0]         state_n;
    logic               unused_addr;

    assign unused_addr = ^addr[1:0];

    assign waddr   = addr[ADDR_W-1:2];
    assign csr_off = waddr - CSR_WORD;
    assign csr_hit = csr_off < WAW'(3);
    assign csr_sel = csr_off[1:0];
    assign csr_wr  = cs && wr && csr_hit;
    assign mem_wr  = cs && wr && !csr_hit;

    // Big-endian: the lowest byte address holds the most significant byte.
    assign mem_word = {mem[{waddr, 2'b00}], mem[{waddr, 2'b01}],
                       mem[{waddr, 2'b10}], mem[{waddr, 2'b11}]};

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[{waddr, 2'b00}] <= in[31:24];
            mem[{waddr, 2'b01}] <= in[23:16];
            mem[{waddr, 2'b10}] <= in[15:8];
            mem[{waddr, 2'b11}] <= in[7:0];
        end
    end

    always_comb begin
        csr_word = '0;
        case (csr_sel)
            CSR_MASK: csr_word[N_CH-1:0] = mask;
            CSR_PEND: csr_word[N_CH-1:0] = pend;
            CSR_VEC:  csr_word = vec_base;
            default:  csr_word = '0;
        endcase
    end

    assign pend_m = pend & mask;

    io_irq_mem_prio_enc #(.N_CH(N_CH)) u_prio (
        .req (pend_m),
        .id  (win_id),
        .any (win_any)
    );

    assign rise     = sync2 & ~prev;
    assign ack_take = (state == ST_IDLE) && inta;
    assign w1c_clr  = (csr_wr && csr_sel == CSR_PEND) ? in[N_CH-1:0] : '0;
    assign ack_clr  = (ack_take && win_any) ? (N_CH'(1) << win_id) : '0;
    // A new edge beats any clear landing on the same bit in the same cycle.
    assign pend_n   = (pend & ~(w1c_clr | ack_clr)) | rise;

    always_comb begin
        state_n = state;
        if (state == ST_IDLE && inta) begin
            state_n = ST_ACK;
        end else if (state == ST_ACK && !inta) begin
            state_n = ST_IDLE;
        end
    end

    // intr follows the registered pending set, so it trails a PEND/MASK change
    // by one cycle and drops on the same edge the ack is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pend     <= '0;
            mask     <= '1;
            vec_base <= VEC_RST;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            intr     <= 1'b0;
            vec_id   <= '0;
        end else begin
            state <= state_n;
            sync1 <= irq_src;
            sync2 <= sync1;
            prev  <= sync2;
            pend  <= pend_n;
            intr  <= (state_n == ST_IDLE) && (|pend_m);
            if (ack_take) begin
                vec_id <= win_id;
            end
            if (csr_wr && csr_sel == CSR_MASK) begin
                mask <= in[N_CH-1:0];
            end
            if (csr_wr && csr_sel == CSR_VEC) begin
                vec_base <= {in[DATA_W-1:2], 2'b00};
            end
        end
    end

    assign vector  = vec_base + DATA_W'({vec_id, 2'b00});
    assign ack_out = (state == ST_ACK) && inta;
    assign drive   = ack_out || (cs && rd);

    // The vector fetch owns the bus during an ack, even over a CPU read.
    assign out = !drive  ? 'z :
                 ack_out ? vector :
                 csr_hit ? csr_word : mem_word;

endmodule

// File: tb/tb_io_irq_mem.sv
// Scoreboard bench for io_irq_mem: stimulus queues expected bus/intr/memory values,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_io_irq_mem;

    localparam int K_BUS  = 0;
    localparam int K_HIZ  = 1;
    localparam int K_INTR = 2;
    localparam int K_MEM  = 3;

    localparam logic [11:0] A_MASK = 12'hFF0;
    localparam logic [11:0] A_PEND = 12'hFF4;
    localparam logic [11:0] A_VEC  = 12'hFF8;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] expv;
        int          adr;
    } chk_t;

    chk_t sb[$];

    logic        clk;
    logic        rst;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] din;
    logic [3:0]  irq_src;
    logic        inta;
    wire         intr;
    wire  [31:0] out_bus;

    int total;
    int bad;
    logic [7:0] shadow_pre;

    io_irq_mem dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .in      (din),
        .irq_src (irq_src),
        .inta    (inta),
        .intr    (intr),
        .out     (out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic c, input logic r, input logic w,
                                  input logic [11:0] a, input logic [31:0] d);
        cs   = c;
        rd   = r;
        wr   = w;
        addr = a;
        din  = d;
    endtask

    task automatic expect_chk(input int kind, input string name,
                              input logic [31:0] v, input int adr = 0);
        chk_t c;
        c.kind = kind;
        c.name = name;
        c.expv = v;
        c.adr  = adr;
        sb.push_back(c);
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        apply_stimulus(1'b1, 1'b0, 1'b1, a, d);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic bus_read(input logic [11:0] a, input logic [31:0] v, input string name);
        apply_stimulus(1'b1, 1'b1, 1'b0, a, 32'h0);
        expect_chk(K_BUS, name, v);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic check_output(input chk_t c);
        total++;
        case (c.kind)
            K_BUS: begin
                if (dut.drive !== 1'b1 || out_bus !== c.expv) begin
                    bad++;
                    $display("[TB] FAIL %s: got out=%h drive=%b, want out=%h driven",
                             c.name, out_bus, dut.drive, c.expv);
                end
            end
            K_HIZ: begin
                if (dut.drive !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL %s: got drive=%b out=%h, want bus released",
                             c.name, dut.drive, out_bus);
                end
            end
            K_INTR: begin
                if (intr !== c.expv[0]) begin
                    bad++;
                    $display("[TB] FAIL %s: got intr=%b, want %b", c.name, intr, c.expv[0]);
                end
            end
            default: begin
                if (dut.mem[c.adr] !== c.expv[7:0]) begin
                    bad++;
                    $display("[TB] FAIL %s: got mem[%h]=%h, want %h",
                             c.name, c.adr, dut.mem[c.adr], c.expv[7:0]);
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        chk_t c;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            check_output(c);
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        inta    = 1'b0;
        irq_src = '0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);

        // Reset state
        step();
        step();
        expect_chk(K_INTR, "rst_intr", 32'h0);
        expect_chk(K_HIZ, "rst_hiz", 32'h0);
        step();
        rst = 1'b1;
        step();
        bus_read(A_MASK, 32'hF, "rst_mask");
        bus_read(A_PEND, 32'h0, "rst_pend");
        bus_read(A_VEC, 32'h3C0, "rst_vec");

        // Memory: big-endian store, combinational read, release, read-during-write
        bus_write(12'h010, 32'hDEADBEEF);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
        expect_chk(K_BUS, "mem_rd", 32'hDEADBEEF);
        expect_chk(K_MEM, "mem_msb", 32'hDE, 'h010);
        expect_chk(K_MEM, "mem_lsb", 32'hEF, 'h013);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 12'h010, 32'h0);
        expect_chk(K_HIZ, "cs0_hiz", 32'h0);
        step();
        apply_stimulus(1'b1, 1'b1, 1'b1, 12'h012, 32'h12345678);
        expect_chk(K_BUS, "rdwr_old", 32'hDEADBEEF);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        bus_read(12'h010, 32'h12345678, "rdwr_new");

        // Single IRQ on channel 2
        irq_src = 4'b0100;
        step();
        irq_src = '0;
        step();
        step();
        expect_chk(K_INTR, "irq2_intr_lat", 32'h0);
        bus_read(A_PEND, 32'h4, "irq2_pend");
        expect_chk(K_INTR, "irq2_intr", 32'h1);
        step();
        inta = 1'b1;
        step();
        expect_chk(K_BUS, "irq2_vec", 32'h3C8);
        expect_chk(K_INTR, "irq2_intr_ack", 32'h0);
        step();
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
        expect_chk(K_BUS, "inta_override", 32'h3C8);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        inta = 1'b0;
        step();
        expect_chk(K_INTR, "irq2_intr_stay", 32'h0);
        bus_read(A_PEND, 32'h0, "irq2_pend_clr");

        // Priority: channels 1 and 3 together
        irq_src = 4'b1010;
        step();
        irq_src = '0;
        step();
        step();
        step();
        expect_chk(K_INTR, "prio_intr", 32'h1);
        bus_read(A_PEND, 32'hA, "prio_pend");
        inta = 1'b1;
        step();
        expect_chk(K_BUS, "prio_vec1", 32'h3C4);
        step();
        inta = 1'b0;
        expect_chk(K_INTR, "prio_intr_low", 32'h0);
        step();
        expect_chk(K_INTR, "prio_intr_re", 32'h1);
        inta = 1'b1;
        step();
        expect_chk(K_BUS, "prio_vec2", 32'h3CC);
        step();
        inta = 1'b0;
        step();
        bus_read(A_PEND, 32'h0, "prio_pend_clr");

        // Mask and write-1-to-clear
        bus_write(A_MASK, 32'h0);
        irq_src = 4'b0001;
        step();
        irq_src = '0;
        step();
        step();
        step();
        expect_chk(K_INTR, "mask_intr", 32'h0);
        bus_read(A_PEND, 32'h1, "mask_pend");
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, 32'h0, "w1c_pend");
        irq_src = 4'b0001;
        step();
        irq_src = '0;
        step();
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, 32'h1, "w1c_set_wins");
        bus_write(A_MASK, 32'hF);
        expect_chk(K_INTR, "unmask_lat", 32'h0);
        step();
        expect_chk(K_INTR, "unmask_intr", 32'h1);
        step();
        inta = 1'b1;
        step();
        expect_chk(K_BUS, "ch0_vec", 32'h3C0);
        step();
        inta = 1'b0;
        step();
        step();

        // VEC_BASE alignment, CSR shadowing, mask upper bits, spurious vector
        shadow_pre = dut.mem['hFF8];
        bus_write(A_VEC, 32'h123);
        bus_read(A_VEC, 32'h120, "vec_align");
        bus_write(A_VEC, 32'h200);
        expect_chk(K_MEM, "vec_shadow", {24'h0, shadow_pre}, 'hFF8);
        bus_read(A_VEC, 32'h200, "vec_rd");
        bus_write(A_MASK, 32'hFFFFFFFF);
        bus_read(A_MASK, 32'hF, "mask_upper0");
        inta = 1'b1;
        step();
        expect_chk(K_BUS, "spurious_vec", 32'h210);
        step();
        inta = 1'b0;
        step();
        step();

        // Reset in the middle of an ack
        irq_src = 4'b0010;
        step();
        irq_src = '0;
        step();
        step();
        step();
        inta = 1'b1;
        step();
        expect_chk(K_BUS, "rst_ack_vec", 32'h204);
        step();
        rst = 1'b0;
        expect_chk(K_HIZ, "rst_ack_hiz", 32'h0);
        expect_chk(K_INTR, "rst_ack_intr", 32'h0);
        step();
        inta = 1'b0;
        bus_read(A_PEND, 32'h0, "rst_ack_pend");
        bus_read(A_MASK, 32'hF, "rst_ack_mask");
        bus_read(A_VEC, 32'h3C0, "rst_ack_vec_base");
        rst = 1'b1;
        step();
        step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
